// File: rtl/muldiv_unit.sv
// rtl/muldiv_unit.sv - multicycle signed/unsigned multiply/divide unit with start/busy/done handshake
// Optional MULDIV_EARLY_OUT_EN: multiplies finish once the remaining multiplier bits are zero.
module muldiv_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;

    state_t             state_q, state_d;
    logic               is_div_q, is_div_d;
    logic               neg_main_q, neg_main_d;
    logic               neg_rem_q, neg_rem_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] x_q, x_d;
    logic [2*WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0]   z_q, z_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               div_zero_q, div_zero_d;

    logic               is_signed;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic [WIDTH:0]     rem_shift, rem_diff;
    logic [2*WIDTH-1:0] prod_signed;

    always_comb begin
        state_d    = state_q;
        is_div_d   = is_div_q;
        neg_main_d = neg_main_q;
        neg_rem_d  = neg_rem_q;
        cnt_d      = cnt_q;
        x_d        = x_q;
        y_d        = y_q;
        z_d        = z_q;
        hi_d       = hi_q;
        lo_d       = lo_q;
        div_zero_d = div_zero_q;

        is_signed   = ~op[0];
        mag_a       = (is_signed && a[WIDTH-1]) ? -a : a;
        mag_b       = (is_signed && b[WIDTH-1]) ? -b : b;
        // x holds {remainder, dividend/quotient} for divide, the running product for multiply
        rem_shift   = x_q[2*WIDTH-1:WIDTH-1];
        rem_diff    = rem_shift - {1'b0, y_q[WIDTH-1:0]};
        prod_signed = neg_main_q ? -x_q : x_q;

        case (state_q)
            IDLE: begin
                if (start) begin
                    div_zero_d = 1'b0;
                    is_div_d   = op[1];
                    neg_main_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
                    neg_rem_d  = is_signed & a[WIDTH-1];
                    cnt_d      = '0;
                    if (op[1] && (b == '0)) begin
                        div_zero_d = 1'b1;
                        state_d    = DONE;
                    end else begin
                        state_d = CALC;
                        if (op[1]) begin
                            x_d = {{WIDTH{1'b0}}, mag_a};
                            y_d = {{WIDTH{1'b0}}, mag_b};
                        end else begin
                            x_d = '0;
                            y_d = {{WIDTH{1'b0}}, mag_a};
                        end
                        z_d = mag_b;
                    end
                end
            end
            CALC: begin
                cnt_d = cnt_q + 1'b1;
                if (is_div_q) begin
                    if (!rem_diff[WIDTH])
                        x_d = {rem_diff[WIDTH-1:0], x_q[WIDTH-2:0], 1'b1};
                    else
                        x_d = {rem_shift[WIDTH-1:0], x_q[WIDTH-2:0], 1'b0};
                end else begin
                    // multiplicand shifts left, so the product is already aligned at every step
                    if (z_q[0])
                        x_d = x_q + y_q;
                    y_d = y_q << 1;
                    z_d = z_q >> 1;
                end
                if (cnt_q == CW'(WIDTH - 1))
                    state_d = FIX;
`ifdef MULDIV_EARLY_OUT_EN
                else if (!is_div_q && (z_q[WIDTH-1:1] == '0))
                    state_d = FIX;
`endif
            end
            FIX: begin
                if (is_div_q) begin
                    lo_d = neg_main_q ? -x_q[WIDTH-1:0] : x_q[WIDTH-1:0];
                    hi_d = neg_rem_q ? -x_q[2*WIDTH-1:WIDTH] : x_q[2*WIDTH-1:WIDTH];
                end else begin
                    {hi_d, lo_d} = prod_signed;
                end
                state_d = DONE;
            end
            DONE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            is_div_q   <= 1'b0;
            neg_main_q <= 1'b0;
            neg_rem_q  <= 1'b0;
            cnt_q      <= '0;
            x_q        <= '0;
            y_q        <= '0;
            z_q        <= '0;
            hi_q       <= '0;
            lo_q       <= '0;
            div_zero_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            is_div_q   <= is_div_d;
            neg_main_q <= neg_main_d;
            neg_rem_q  <= neg_rem_d;
            cnt_q      <= cnt_d;
            x_q        <= x_d;
            y_q        <= y_d;
            z_q        <= z_d;
            hi_q       <= hi_d;
            lo_q       <= lo_d;
            div_zero_q <= div_zero_d;
        end
    end

    assign busy     = (state_q == CALC) || (state_q == FIX);
    assign done     = (state_q == DONE);
    assign div_zero = div_zero_q;
    assign hi       = hi_q;
    assign lo       = lo_q;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb/tb_muldiv_unit.sv - scoreboard bench for muldiv_unit at WIDTH=32 and WIDTH=8
module tb_muldiv_unit;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start32, busy32, done32, dz32;
    logic [1:0]  op32;
    logic [31:0] a32, b32, hi32, lo32;
    logic        start8, busy8, done8, dz8;
    logic [1:0]  op8;
    logic [7:0]  a8, b8, hi8, lo8;

    muldiv_unit #(.WIDTH(32)) dut32 (
        .clk(clk), .reset(rst_n), .start(start32), .op(op32), .a(a32), .b(b32),
        .busy(busy32), .done(done32), .div_zero(dz32), .hi(hi32), .lo(lo32)
    );

    muldiv_unit #(.WIDTH(8)) dut8 (
        .clk(clk), .reset(rst_n), .start(start8), .op(op8), .a(a8), .b(b8),
        .busy(busy8), .done(done8), .div_zero(dz8), .hi(hi8), .lo(lo8)
    );

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          lat;
        int          t0;
    } exp_t;

    exp_t q32[$];
    exp_t q8[$];
    exp_t e32, e8;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Latency of a non-zero-divisor operation for a given op and multiplier.
    function automatic int op_lat(input logic [1:0] op, input logic [31:0] b, input int w);
`ifdef MULDIV_EARLY_OUT_EN
        if (!op[1]) begin
            logic [31:0] m;
            int k;
            m = (!op[0] && b[w-1]) ? -b : b;
            k = 1;
            for (int i = 0; i < w; i++)
                if (m[i]) k = i + 1;
            return k + 2;
        end
`endif
        return w + 2;
    endfunction

    always @(negedge clk) begin
        if (rst_n && done32) begin
            if (q32.size() == 0) begin
                chk("unexpected_done32", 1'b1, 1'b0);
            end else begin
                e32 = q32.pop_front();
                chk("hi32", hi32, e32.hi);
                chk("lo32", lo32, e32.lo);
                chk("div_zero32", dz32, e32.dz);
                chk("latency32", cyc - e32.t0, e32.lat);
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && done8) begin
            if (q8.size() == 0) begin
                chk("unexpected_done8", 1'b1, 1'b0);
            end else begin
                e8 = q8.pop_front();
                chk("hi8", {24'd0, hi8}, e8.hi);
                chk("lo8", {24'd0, lo8}, e8.lo);
                chk("div_zero8", dz8, e8.dz);
                chk("latency8", cyc - e8.t0, e8.lat);
            end
        end
    end

    task automatic run(input bit w8, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp_hi, input logic [31:0] exp_lo, input bit dz, input bit glitch);
        exp_t e;
        int   n;
        bit   seen;
        @(negedge clk);
        e.hi  = exp_hi;
        e.lo  = exp_lo;
        e.dz  = dz;
        e.lat = dz ? 1 : op_lat(op, b, w8 ? 8 : 32);
        e.t0  = cyc;
        if (w8) begin
            op8 = op; a8 = a[7:0]; b8 = b[7:0]; start8 = 1'b1;
            q8.push_back(e);
        end else begin
            op32 = op; a32 = a; b32 = b; start32 = 1'b1;
            q32.push_back(e);
        end
        @(negedge clk);
        start8  = 1'b0;
        start32 = 1'b0;
        chk(w8 ? "div_zero_after_start8" : "div_zero_after_start32", w8 ? dz8 : dz32, dz);
        n    = 0;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            if (w8 ? done8 : done32) begin
                seen = 1;
            end else begin
                if (w8 ? busy8 : busy32) n++;
                if (glitch && n == 5) begin
                    start32 = 1'b1; op32 = 2'b01; a32 = 32'd100; b32 = 32'd100;
                end else begin
                    start32 = 1'b0;
                end
                @(negedge clk);
            end
        end
        chk("done_seen", seen, 1'b1);
        chk("busy_cycles", n, dz ? 0 : e.lat - 1);
    endtask

    initial begin
        rst_n = 1'b0;
        start32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
        start8 = 1'b0; op8 = 2'b00; a8 = '0; b8 = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_busy", busy32, 1'b0);
        chk("reset_done", done32, 1'b0);
        chk("reset_div_zero", dz32, 1'b0);
        chk("reset_hilo", {hi32, lo32}, 64'd0);

        run(0, 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 0, 0);
        run(0, 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 0, 0);
        run(0, 2'b01, 32'd5, 32'd3, 32'd0, 32'd15, 0, 0);
        run(0, 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'h00000000, 0, 0);
        run(0, 2'b00, 32'h80000000, 32'd1, 32'hFFFFFFFF, 32'h80000000, 0, 0);
        run(0, 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 0, 0);
        run(0, 2'b11, 32'd7, 32'd2, 32'd1, 32'd3, 0, 0);
        run(0, 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 0, 0);
        run(0, 2'b10, 32'hFFFFFFF9, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'd3, 0, 0);
        run(0, 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 0, 0);
        run(0, 2'b11, 32'd9, 32'd0, 32'd0, 32'h80000000, 1, 0);
        run(0, 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 0, 0);
        run(0, 2'b00, 32'hFFFFFFFC, 32'd3, 32'hFFFFFFFF, 32'hFFFFFFF4, 0, 1);

        @(negedge clk);
        op32 = 2'b01; a32 = 32'd1000; b32 = 32'd1000; start32 = 1'b1;
        @(negedge clk);
        start32 = 1'b0;
        repeat (5) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_busy", busy32, 1'b0);
        chk("async_reset_done", done32, 1'b0);
        chk("async_reset_hilo", {hi32, lo32}, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        run(0, 2'b01, 32'd6, 32'd7, 32'd0, 32'd42, 0, 0);

        run(1, 2'b10, 32'h81, 32'h03, 32'hFF, 32'hD6, 0, 0);
        run(1, 2'b11, 32'h81, 32'h03, 32'h00, 32'h2B, 0, 0);
        run(1, 2'b00, 32'h80, 32'h80, 32'h40, 32'h00, 0, 0);
        run(1, 2'b10, 32'h05, 32'h00, 32'h40, 32'h00, 1, 0);

        repeat (3) @(negedge clk);
        chk("scoreboard32_drained", q32.size(), 0);
        chk("scoreboard8_drained", q8.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
